tcdev_reg_arb: RTL
==================

TCDEV_REG_ARB -- requirements
Module: tcdev_reg_arb

Interface
REQ-001 Parameter NREQ, default 2, number of requesters; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 16, maximum wait cycles for target ready; legal range 2..255.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous assertion, active-high.
REQ-005 req_valid_i  input  NREQ  per-requester request pending.
REQ-006 req_addr_i  input  32*NREQ  per-requester address; slice k = bits [32k+31:32k].
REQ-007 req_wdata_i  input  32*NREQ  per-requester write data, same slicing.
REQ-008 req_we_i  input  NREQ  per-requester write enable (1 = write, 0 = read).
REQ-009 req_gnt_o  output  NREQ  one-cycle grant pulse; request accepted in that cycle.
REQ-010 rsp_valid_o  output  NREQ  one-cycle response pulse to the owning requester.
REQ-011 rsp_rdata_o  output  32  response read data, shared by all requesters.
REQ-012 rsp_err_o  output  1  response error flag; qualified by any rsp_valid_o bit.
REQ-013 reg_en_o, reg_addr_o[32], reg_wdata_o[32], reg_we_o  output  target register bus.
REQ-014 reg_rdata_i  input  32  target read data, valid the cycle after the accepting cycle.
REQ-015 reg_ready_i  input  1  target accepts when reg_en_o & reg_ready_i.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; exactly one state active at any time.
REQ-017 IDLE with no req_valid_i bit set: remain in IDLE with all outputs low.
REQ-018 IDLE with any req_valid_i bit set: grant the first set bit found searching upward from rr_ptr, with wrap-around.
REQ-019 On a grant: pulse req_gnt_o[winner]; latch the winner's addr, wdata and we plus the owner index; go to ACCESS.
REQ-020 Requester contract: on req_gnt_o the requester either drops valid or presents a new request; the block never samples an ungranted request.
REQ-021 ACCESS: drive reg_en_o=1 and the latched addr, wdata and we; the wait counter starts at 0.
REQ-022 ACCESS with reg_ready_i=1: go to RESP with err=0.
REQ-023 ACCESS with reg_ready_i=0: increment the counter; when the counter reaches TIMEOUT-1, go to RESP with err=1.
REQ-024 A ready arriving in the same cycle as the timeout takes precedence: err=0.
REQ-025 RESP: pulse rsp_valid_o[owner]; drive rsp_rdata_o = reg_rdata_i if err=0, else 32'h0; drive rsp_err_o = err.
REQ-026 RESP: set rr_ptr to (owner+1) mod NREQ; go to IDLE.
REQ-027 Write responses also return reg_rdata_i; the requester ignores that data.
REQ-028 rsp_rdata_o and rsp_err_o are 0 whenever no rsp_valid_o bit is set.
REQ-029 reg_en_o is 0 outside ACCESS.
REQ-030 reg_addr_o, reg_wdata_o and reg_we_o hold their last latched value outside ACCESS.
REQ-031 Latency with reg_ready_i tied high: grant at cycle t, reg_en_o at t+1, response at t+2, next grant at t+3 at the earliest.
REQ-032 At most one bit of req_gnt_o is set per cycle, and at most one bit of rsp_valid_o.
REQ-033 Every grant is followed by exactly one response to the same requester.

Reset
REQ-034 While rst_i is high: state=IDLE, rr_ptr=0, counter=0, err=0, latched registers=0, all outputs 0.
REQ-035 Reset asserted mid-transaction abandons it with no response.
REQ-036 After reset deasserts, the first grant is evaluated on the next rising edge.

Structure
REQ-037 Shared package tcdev_pkg holds the FSM state enum and the TIMEOUT default constant.
REQ-038 Sub-module tcdev_rr_pick: combinational round-robin picker taking valid[NREQ] and ptr, returning onehot grant and index.
REQ-039 Total RTL is one module plus the picker; no memories.

Verification
REQ-040 Single read: req0 read at addr 0x0400_0004, ready=1, target returns 0x1234_5678 -> gnt0 at t, reg_en at t+1, rsp_valid0 at t+2 with rdata 0x1234_5678 and err=0.
REQ-041 Contention: req0 and req1 both valid continuously after reset -> grant order 0,1,0,1; no grant gap longer than 3 cycles.
REQ-042 Timeout: ready held at 0, TIMEOUT=16 -> reg_en high for 16 cycles, then rsp_err=1 and rdata=0.
REQ-043 Ready at boundary: ready=1 exactly on the 16th ACCESS cycle -> err=0 and the target data is returned.
REQ-044 Reset mid-ACCESS: assert rst_i while reg_en_o=1 -> all outputs 0 immediately, no rsp_valid, next grant goes to req0.
REQ-045 Write: req1 write 0xA5A5_A5A5 to 0x0401_0000 -> reg_we_o=1 and reg_wdata_o match during reg_en_o, rsp_valid1 two cycles after gnt1.

Source files
------------

// File: rtl/tcdev_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcdev_pkg
// Purpose  : Shared types and constants for the tcdev register arbiter.
//            Holds the arbiter FSM state encoding, the default target
//            timeout and a helper for sizing requester index fields.
// Revision : 1.0 - initial release
// ============================================================================
package tcdev_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Default maximum number of wait cycles for target ready
  localparam int c_timeout_default = 16;

  // Width of a requester index for 2..4 requesters
  function automatic int idx_width(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcdev_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : tcdev_rr_pick
// Purpose  : Combinational round-robin picker. Searches valid_i upward from
//            ptr_i with wrap-around and returns the first set requester.
// Ports    : valid_i [NREQ]  request pending per requester
//            ptr_i   [IW]    search start index
//            gnt_o   [NREQ]  one-hot winner (all zero when nothing valid)
//            idx_o   [IW]    winner index (0 when nothing valid)
// Revision : 1.0 - initial release
// ============================================================================
module tcdev_rr_pick
  import tcdev_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Candidate i positions after the pointer, wrapping at NREQ
      w_cand = IW'((int'(ptr_i) + i) % NREQ);
      if (!w_found && valid_i[w_cand]) begin
        w_found        = 1'b1;
        gnt_o[w_cand]  = 1'b1;
        idx_o          = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcdev_reg_arb.sv
`default_nettype none
// ============================================================================
// Module   : tcdev_reg_arb
// Purpose  : Round-robin arbiter giving NREQ requesters access to a single
//            target register bus, one transaction at a time, with a bounded
//            wait for target ready (timeout returns an error response).
// Ports    : clk_i, rst_i (async, active-high)
//            req_valid_i/addr_i/wdata_i/we_i  per-requester request inputs
//            req_gnt_o    one-cycle grant pulse per requester
//            rsp_valid_o  one-cycle response pulse to the owner
//            rsp_rdata_o, rsp_err_o  shared response payload
//            reg_en_o/addr_o/wdata_o/we_o, reg_rdata_i, reg_ready_i  target bus
// Revision : 1.0 - initial release
// ============================================================================
module tcdev_reg_arb
  import tcdev_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [32*NREQ-1:0] req_addr_i,
  input  logic [32*NREQ-1:0] req_wdata_i,
  input  logic [NREQ-1:0]   req_we_i,
  output logic [NREQ-1:0]   req_gnt_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              reg_en_o,
  output logic [31:0]       reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  output logic              reg_we_o,
  input  logic [31:0]       reg_rdata_i,
  input  logic              reg_ready_i
);

  localparam int c_iw = idx_width(NREQ);

  state_t          r_state,  w_state_nxt;
  logic [c_iw-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [c_iw-1:0] r_owner,  w_owner_nxt;
  logic [31:0]     r_addr,   w_addr_nxt;
  logic [31:0]     r_wdata,  w_wdata_nxt;
  logic            r_we,     w_we_nxt;
  logic            r_err,    w_err_nxt;
  logic [7:0]      r_cnt,    w_cnt_nxt;

  logic [NREQ-1:0] w_pick_gnt;
  logic [c_iw-1:0] w_pick_idx;

  tcdev_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (r_rr_ptr),
    .gnt_o   (w_pick_gnt),
    .idx_o   (w_pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = r_we;
    w_err_nxt    = r_err;
    w_cnt_nxt    = r_cnt;
    req_gnt_o    = '0;
    rsp_valid_o  = '0;
    rsp_rdata_o  = '0;
    rsp_err_o    = 1'b0;
    reg_en_o     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|req_valid_i) begin
          req_gnt_o   = w_pick_gnt;
          w_owner_nxt = w_pick_idx;
          for (int k = 0; k < NREQ; k++) begin
            if (w_pick_gnt[k]) begin
              w_addr_nxt  = req_addr_i[32*k +: 32];
              w_wdata_nxt = req_wdata_i[32*k +: 32];
              w_we_nxt    = req_we_i[k];
            end
          end
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        reg_en_o = 1'b1;
        // Ready wins over a timeout landing in the same cycle
        if (reg_ready_i) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_RESP;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      ST_RESP: begin
        rsp_valid_o[r_owner] = 1'b1;
        rsp_rdata_o          = r_err ? 32'h0 : reg_rdata_i;
        rsp_err_o            = r_err;
        w_rr_ptr_nxt         = (r_owner == c_iw'(NREQ - 1)) ? '0 : r_owner + c_iw'(1);
        w_state_nxt          = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // State is already forced to IDLE by the async reset; the grant pulse is
    // the only output that could still follow live request inputs.
    if (rst_i) begin
      req_gnt_o = '0;
    end
  end

  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = r_we;

endmodule
`default_nettype wire
